// File: rtl/usb3_lfps_tx.sv
// usb3_lfps_tx -- USB3 LFPS transmit sequencer.
//
// Drives PIPE TxElecIdle/TxOnesZeros to send Polling.LFPS (repeating),
// Ping, U1/U2/U3-exit (with partner handshake and timeout) and, optionally,
// Warm Reset LFPS. One down-counter times every burst and gap.
//
// Build option: define USB3_LFPS_TX_WARM_RESET_EN to include the Warm Reset
// burst (WARM state, 24-bit counter). Without it send_warm_reset is ignored
// and the counter is 18 bits wide.
module usb3_lfps_tx #(
    parameter int POLL_BURST  = 125,
    parameter int POLL_REPEAT = 1250,
    parameter int PING_BURST  = 16,
    parameter int UEXIT_MIN   = 75,
    parameter int UEXIT_MAX   = 250000,
    parameter int WARM_BURST  = 12500000
) (
    input  logic       local_clk,
    input  logic       reset,
    input  logic       send_poll,
    input  logic       send_ping,
    input  logic       send_u_exit,
    input  logic       send_warm_reset,
    input  logic       stop,
    input  logic       handshake_ok,
    output logic       tx_elecidle,
    output logic       tx_oneszeros,
    output logic       busy,
    output logic       done,
    output logic       timeout,
    output logic [7:0] poll_bursts
);

`ifdef USB3_LFPS_TX_WARM_RESET_EN
    localparam int CW = 24;
`else
    localparam int CW = 18;
`endif

    typedef enum logic [2:0] {
        IDLE,
        POLL_ON,
        POLL_OFF,
        PING,
        UEXIT
`ifdef USB3_LFPS_TX_WARM_RESET_EN
        , WARM
`endif
    } state_t;

    // Counter load values: a state loaded with N-1 lasts exactly N cycles,
    // leaving when the counter reads zero.
    localparam logic [CW-1:0] POLL_ON_LOAD  = CW'(POLL_BURST - 1);
    localparam logic [CW-1:0] POLL_OFF_LOAD = CW'(POLL_REPEAT - POLL_BURST - 1);
    localparam logic [CW-1:0] PING_LOAD     = CW'(PING_BURST - 1);
    localparam logic [CW-1:0] UEXIT_LOAD    = CW'(UEXIT_MAX - 1);
    // In UEXIT the counter reads UEXIT_MAX - n during burst cycle n (1-based),
    // so the minimum burst length has been reached once it drops to this value.
    localparam logic [CW-1:0] UEXIT_MIN_CNT = CW'(UEXIT_MAX - UEXIT_MIN);

`ifdef USB3_LFPS_TX_WARM_RESET_EN
    localparam logic [CW-1:0] WARM_LOAD     = CW'(WARM_BURST - 1);
`else
    // Warm Reset is compiled out: the parameter and request port stay for
    // interface compatibility but drive nothing.
    localparam int unused_warm_burst = WARM_BURST;
    logic unused_warm_req;
    assign unused_warm_req = send_warm_reset;
`endif

    state_t      state;
    state_t      state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic        hs_latch;
    logic        hs_latch_nxt;
    logic        elecidle_nxt;
    logic        done_nxt;
    logic        timeout_nxt;
    logic [7:0]  poll_bursts_nxt;

    // State, counter, handshake latch and registered outputs.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed by the combinational block.
    always_ff @(posedge local_clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            hs_latch    <= 1'b0;
            tx_elecidle <= 1'b1;
            done        <= 1'b0;
            timeout     <= 1'b0;
            poll_bursts <= 8'd0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            hs_latch    <= hs_latch_nxt;
            tx_elecidle <= elecidle_nxt;
            done        <= done_nxt;
            timeout     <= timeout_nxt;
            poll_bursts <= poll_bursts_nxt;
        end
    end

    // Next-state, counter and output decode; requests are only looked at in IDLE.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a value unassigned, which would infer a latch.
        state_nxt       = state;
        cnt_nxt         = cnt - 1'b1;
        hs_latch_nxt    = hs_latch;
        done_nxt        = 1'b0;
        timeout_nxt     = 1'b0;
        poll_bursts_nxt = poll_bursts;

        if (stop) begin
            // Abort beats everything, including a request in the same cycle.
            state_nxt    = IDLE;
            cnt_nxt      = '0;
            hs_latch_nxt = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_nxt      = '0;
                    hs_latch_nxt = 1'b0;
`ifdef USB3_LFPS_TX_WARM_RESET_EN
                    if (send_warm_reset) begin
                        state_nxt = WARM;
                        cnt_nxt   = WARM_LOAD;
                    end else
`endif
                    if (send_u_exit) begin
                        state_nxt = UEXIT;
                        cnt_nxt   = UEXIT_LOAD;
                    end else if (send_poll) begin
                        // Accepting a poll request clears the count, and this
                        // edge also starts the first burst.
                        state_nxt       = POLL_ON;
                        cnt_nxt         = POLL_ON_LOAD;
                        poll_bursts_nxt = 8'd1;
                    end else if (send_ping) begin
                        state_nxt = PING;
                        cnt_nxt   = PING_LOAD;
                    end
                end

                POLL_ON: begin
                    if (cnt == '0) begin
                        state_nxt = POLL_OFF;
                        cnt_nxt   = POLL_OFF_LOAD;
                    end
                end

                POLL_OFF: begin
                    if (cnt == '0) begin
                        state_nxt = POLL_ON;
                        cnt_nxt   = POLL_ON_LOAD;
                        if (poll_bursts != 8'hFF) begin
                            poll_bursts_nxt = poll_bursts + 8'd1;
                        end
                    end
                end

                PING: begin
                    if (cnt == '0) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end

                UEXIT: begin
                    // The partner indication is sticky for the rest of the
                    // burst; it only ends the burst once the minimum is met.
                    hs_latch_nxt = hs_latch | handshake_ok;
                    if (hs_latch && (cnt <= UEXIT_MIN_CNT)) begin
                        state_nxt    = IDLE;
                        cnt_nxt      = '0;
                        hs_latch_nxt = 1'b0;
                        done_nxt     = 1'b1;
                    end else if (cnt == '0) begin
                        state_nxt    = IDLE;
                        hs_latch_nxt = 1'b0;
                        timeout_nxt  = 1'b1;
                    end
                end

`ifdef USB3_LFPS_TX_WARM_RESET_EN
                WARM: begin
                    if (cnt == '0) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
`endif

                default: begin
                    state_nxt    = IDLE;
                    cnt_nxt      = '0;
                    hs_latch_nxt = 1'b0;
                end
            endcase
        end

        // The transmitter is quiet in IDLE and in the polling gap.
        elecidle_nxt = (state_nxt == IDLE) || (state_nxt == POLL_OFF);
    end

    assign busy         = (state != IDLE);
    assign tx_oneszeros = ~tx_elecidle;

    // Completion and timeout are mutually exclusive endings of a burst.
    assert property (@(posedge local_clk) disable iff (reset) !(done && timeout));

    // A burst is always driven from a non-IDLE state.
    assert property (@(posedge local_clk) disable iff (reset) (!tx_elecidle) |-> busy);

endmodule

// File: tb/tb_usb3_lfps_tx.sv
// Self-checking bench for usb3_lfps_tx. Expected burst lengths, pulse
// positions and burst counts come from the LFPS timing rules computed with
// plain arithmetic; the U-exit timeout is shortened to keep the run short.
module tb_usb3_lfps_tx;

    localparam int POLL_BURST  = 125;
    localparam int POLL_REPEAT = 1250;
    localparam int PING_BURST  = 16;
    localparam int UEXIT_MIN   = 75;
    localparam int UEXIT_MAX   = 2000;
    localparam int WARM_BURST  = 1000;

    logic       local_clk = 1'b0;
    logic       reset;
    logic       send_poll;
    logic       send_ping;
    logic       send_u_exit;
    logic       send_warm_reset;
    logic       stop;
    logic       handshake_ok;
    logic       tx_elecidle;
    logic       tx_oneszeros;
    logic       busy;
    logic       done;
    logic       timeout;
    logic [7:0] poll_bursts;

    int checks   = 0;
    int failures = 0;

    // Per-scenario observation summary, cycle numbers are 1-based from the
    // first edge after the request was sampled.
    typedef struct {
        int first_low;
        int last_low;
        int low_cnt;
        int busy_cnt;
        int done_cnt;
        int done_at;
        int to_cnt;
        int to_at;
        int overlap;
        int oz_bad;
    } obs_t;

    usb3_lfps_tx #(
        .POLL_BURST  (POLL_BURST),
        .POLL_REPEAT (POLL_REPEAT),
        .PING_BURST  (PING_BURST),
        .UEXIT_MIN   (UEXIT_MIN),
        .UEXIT_MAX   (UEXIT_MAX),
        .WARM_BURST  (WARM_BURST)
    ) dut (
        .local_clk       (local_clk),
        .reset           (reset),
        .send_poll       (send_poll),
        .send_ping       (send_ping),
        .send_u_exit     (send_u_exit),
        .send_warm_reset (send_warm_reset),
        .stop            (stop),
        .handshake_ok    (handshake_ok),
        .tx_elecidle     (tx_elecidle),
        .tx_oneszeros    (tx_oneszeros),
        .busy            (busy),
        .done            (done),
        .timeout         (timeout),
        .poll_bursts     (poll_bursts)
    );

    always #4 local_clk = ~local_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    // Expected U-exit burst length when the partner is seen in burst cycle h
    // (0 = never): the latch is visible one cycle later, the burst cannot end
    // before UEXIT_MIN, and a latch arriving after UEXIT_MAX is too late.
    function automatic bit uexit_times_out(input int h);
        return (h == 0) || (h + 1 > UEXIT_MAX);
    endfunction

    function automatic int uexit_len(input int h);
        if (uexit_times_out(h)) return UEXIT_MAX;
        return (h + 1 > UEXIT_MIN) ? h + 1 : UEXIT_MIN;
    endfunction

    // Polling: burst k (0-based) occupies cycles k*REPEAT+1 .. k*REPEAT+BURST.
    function automatic bit poll_low(input int i);
        return ((i - 1) % POLL_REPEAT) < POLL_BURST;
    endfunction

    function automatic int poll_count(input int i);
        int n;
        n = (i - 1) / POLL_REPEAT + 1;
        return (n > 255) ? 255 : n;
    endfunction

    // ---------------- stimulus helpers ----------------
    // mask bits: [3] warm reset, [2] u-exit, [1] poll, [0] ping
    task automatic set_req(input logic [3:0] m);
        send_warm_reset = m[3];
        send_u_exit     = m[2];
        send_poll       = m[1];
        send_ping       = m[0];
    endtask

    task automatic issue(input logic [3:0] m);
        set_req(m);
        @(negedge local_clk);
        set_req(4'b0000);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge local_clk);
    endtask

    task automatic observe(input int n, input int hs_cycle, input int inj_cycle,
                           input logic [3:0] inj_mask, output obs_t o);
        o = '{default: 0};
        for (int i = 1; i <= n; i++) begin
            if (tx_elecidle === 1'b0) begin
                if (o.first_low == 0) o.first_low = i;
                o.last_low = i;
                o.low_cnt++;
            end
            if (tx_oneszeros !== ~tx_elecidle) o.oz_bad++;
            if (busy === 1'b1) o.busy_cnt++;
            if (done === 1'b1) begin o.done_cnt++; o.done_at = i; end
            if (timeout === 1'b1) begin o.to_cnt++; o.to_at = i; end
            if (done === 1'b1 && timeout === 1'b1) o.overlap++;
            handshake_ok = (i == hs_cycle);
            set_req((i == inj_cycle) ? inj_mask : 4'b0000);
            @(negedge local_clk);
        end
        handshake_ok = 1'b0;
        set_req(4'b0000);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        stop = 1'b0;
        handshake_ok = 1'b0;
        reset = 1'b1;
        set_req(4'b0111);
        idle_cycles(3);
        checks++;
        if ({tx_elecidle, tx_oneszeros, busy, done, timeout} !== 5'b10000) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected 10000",
                     {tx_elecidle, tx_oneszeros, busy, done, timeout});
        end
        checks++;
        if (poll_bursts !== 8'd0) begin
            failures++;
            $display("FAIL reset_poll_bursts: got %0d expected 0", poll_bursts);
        end
        set_req(4'b0000);
        reset = 1'b0;
        issue(4'b0001);
        checks++;
        if (tx_elecidle !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_first_req: got elecidle=%b busy=%b expected 0/1",
                     tx_elecidle, busy);
        end
        idle_cycles(20);
    endtask

    task automatic test_poll;
        int   elec_bad = 0;
        int   pb_bad   = 0;
        int   busy_bad = 0;
        int   starts   = 0;
        int   dones    = 0;
        logic prev_idle = 1'b1;
        issue(4'b0010);
        for (int i = 1; i <= 4375; i++) begin
            if (tx_elecidle !== !poll_low(i)) elec_bad++;
            if (tx_oneszeros !== poll_low(i)) elec_bad++;
            if (poll_bursts !== 8'(poll_count(i))) pb_bad++;
            if (busy !== 1'b1) busy_bad++;
            if (done === 1'b1) dones++;
            if (prev_idle === 1'b1 && tx_elecidle === 1'b0) starts++;
            prev_idle = tx_elecidle;
            @(negedge local_clk);
        end
        checks++;
        if (elec_bad != 0) begin
            failures++;
            $display("FAIL poll_waveform: got %0d bad cycles expected 0", elec_bad);
        end
        checks++;
        if (pb_bad != 0) begin
            failures++;
            $display("FAIL poll_count_track: got %0d bad cycles expected 0", pb_bad);
        end
        checks++;
        if (starts != 4 || poll_bursts !== 8'd4) begin
            failures++;
            $display("FAIL poll_bursts: got starts=%0d count=%0d expected 4/4",
                     starts, poll_bursts);
        end
        checks++;
        if (dones != 0 || busy_bad != 0) begin
            failures++;
            $display("FAIL poll_done_busy: got done=%0d busy_bad=%0d expected 0/0",
                     dones, busy_bad);
        end
        stop = 1'b1;
        @(negedge local_clk);
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || tx_elecidle !== 1'b1) begin
            failures++;
            $display("FAIL poll_stop: got busy=%b elecidle=%b expected 0/1", busy, tx_elecidle);
        end
        idle_cycles(3);
    endtask

    task automatic test_ping;
        obs_t       o;
        int         inj;
        logic [3:0] m;
        for (int k = 0; k < 4; k++) begin
            idle_cycles($urandom_range(0, 5));
            inj = $urandom_range(2, PING_BURST);
            m   = 4'($urandom_range(1, 15));
            issue(4'b0001);
            observe(PING_BURST + 14, 0, inj, m, o);
            checks++;
            if (o.first_low != 1 || o.low_cnt != PING_BURST || o.last_low != PING_BURST) begin
                failures++;
                $display("FAIL ping_burst: got first=%0d len=%0d last=%0d expected 1/%0d/%0d (inject %b at %0d)",
                         o.first_low, o.low_cnt, o.last_low, PING_BURST, PING_BURST, m, inj);
            end
            checks++;
            if (o.done_cnt != 1 || o.done_at != PING_BURST + 1 || o.to_cnt != 0) begin
                failures++;
                $display("FAIL ping_done: got done=%0d at %0d timeout=%0d expected 1 at %0d, 0",
                         o.done_cnt, o.done_at, o.to_cnt, PING_BURST + 1);
            end
            checks++;
            if (o.busy_cnt != PING_BURST || o.oz_bad != 0) begin
                failures++;
                $display("FAIL ping_busy: got busy=%0d oz_bad=%0d expected %0d/0",
                         o.busy_cnt, o.oz_bad, PING_BURST);
            end
        end
    endtask

    task automatic test_uexit;
        int   hs_list[$] = '{10, 500, 74, 75, 1999, 2000, 0};
        obs_t o;
        int   len;
        bit   to;
        for (int k = 0; k < 3; k++) hs_list.push_back(int'($urandom_range(1, 400)));
        foreach (hs_list[k]) begin
            len = uexit_len(hs_list[k]);
            to  = uexit_times_out(hs_list[k]);
            idle_cycles($urandom_range(1, 4));
            issue(4'b0100);
            observe(len + 4, hs_list[k], 0, 4'b0000, o);
            checks++;
            if (o.first_low != 1 || o.low_cnt != len || o.last_low != len || o.busy_cnt != len) begin
                failures++;
                $display("FAIL uexit_len hs=%0d: got first=%0d len=%0d last=%0d busy=%0d expected 1/%0d",
                         hs_list[k], o.first_low, o.low_cnt, o.last_low, o.busy_cnt, len);
            end
            checks++;
            if (o.done_cnt != (to ? 0 : 1) || o.to_cnt != (to ? 1 : 0) ||
                (to ? o.to_at : o.done_at) != len + 1 || o.overlap != 0) begin
                failures++;
                $display("FAIL uexit_end hs=%0d: got done=%0d@%0d timeout=%0d@%0d expected %s at %0d",
                         hs_list[k], o.done_cnt, o.done_at, o.to_cnt, o.to_at,
                         to ? "timeout" : "done", len + 1);
            end
        end
    endtask

    task automatic test_warm;
        obs_t o;
`ifdef USB3_LFPS_TX_WARM_RESET_EN
        int len = WARM_BURST;
`else
        int len = PING_BURST;
`endif
        idle_cycles(2);
        issue(4'b1001);
        observe(len + 20, 0, 0, 4'b0000, o);
        checks++;
        if (o.first_low != 1 || o.low_cnt != len || o.last_low != len) begin
            failures++;
            $display("FAIL warm_vs_ping: got first=%0d len=%0d last=%0d expected 1/%0d/%0d",
                     o.first_low, o.low_cnt, o.last_low, len, len);
        end
        checks++;
        if (o.done_cnt != 1 || o.done_at != len + 1) begin
            failures++;
            $display("FAIL warm_done: got %0d at %0d expected 1 at %0d", o.done_cnt, o.done_at, len + 1);
        end
    endtask

    task automatic test_priority;
        obs_t       o;
        logic [3:0] m;
        int exp_low, exp_busy, exp_done, exp_done_at, win;
        for (int k = 0; k < 6; k++) begin
            m = 4'($urandom_range(1, 15));
`ifdef USB3_LFPS_TX_WARM_RESET_EN
            if (m[3])      begin exp_low = WARM_BURST; win = WARM_BURST + 4; end else
`endif
            if (m[2])      begin exp_low = UEXIT_MIN;  win = UEXIT_MIN + 4;  end
            else if (m[1]) begin exp_low = POLL_BURST; win = 300;            end
            else if (m[0]) begin exp_low = PING_BURST; win = PING_BURST + 4; end
            else           begin exp_low = 0;          win = 20;             end
            if (!m[3] || win == WARM_BURST + 4) begin end
            exp_busy    = (exp_low == POLL_BURST && win == 300) ? 300 : exp_low;
            exp_done    = (exp_low == 0 || win == 300) ? 0 : 1;
            exp_done_at = (exp_done == 1) ? exp_low + 1 : 0;
            idle_cycles(2);
            issue(m);
            observe(win, 5, 0, 4'b0000, o);
            checks++;
            if (o.low_cnt != exp_low || o.last_low != exp_low || o.busy_cnt != exp_busy ||
                o.done_cnt != exp_done || o.done_at != exp_done_at) begin
                failures++;
                $display("FAIL priority mask=%b: got len=%0d last=%0d busy=%0d done=%0d@%0d expected %0d/%0d/%0d/%0d@%0d",
                         m, o.low_cnt, o.last_low, o.busy_cnt, o.done_cnt, o.done_at,
                         exp_low, exp_low, exp_busy, exp_done, exp_done_at);
            end
            stop = 1'b1;
            @(negedge local_clk);
            stop = 1'b0;
        end
    endtask

    task automatic test_stop;
        obs_t o;
        issue(4'b0010);
        idle_cycles(49);
        stop = 1'b1;
        @(negedge local_clk);
        stop = 1'b0;
        checks++;
        if ({tx_elecidle, busy, done, timeout} !== 4'b1000) begin
            failures++;
            $display("FAIL stop_poll_on: got %b expected 1000", {tx_elecidle, busy, done, timeout});
        end
        observe(20, 0, 0, 4'b0000, o);
        checks++;
        if (o.low_cnt != 0 || o.busy_cnt != 0 || o.done_cnt != 0 || o.to_cnt != 0) begin
            failures++;
            $display("FAIL stop_after: got low=%0d busy=%0d done=%0d timeout=%0d expected 0",
                     o.low_cnt, o.busy_cnt, o.done_cnt, o.to_cnt);
        end
        stop = 1'b1;
        issue(4'b0101);
        stop = 1'b0;
        observe(20, 0, 0, 4'b0000, o);
        checks++;
        if (o.low_cnt != 0 || o.busy_cnt != 0 || o.done_cnt != 0) begin
            failures++;
            $display("FAIL stop_wins: got low=%0d busy=%0d done=%0d expected 0",
                     o.low_cnt, o.busy_cnt, o.done_cnt);
        end
    endtask

    task automatic test_reset_mid;
        obs_t o;
        issue(4'b0100);
        idle_cycles(29);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({tx_elecidle, tx_oneszeros, busy, done, timeout} !== 5'b10000) begin
            failures++;
            $display("FAIL reset_mid_uexit: got %b expected 10000",
                     {tx_elecidle, tx_oneszeros, busy, done, timeout});
        end
        @(negedge local_clk);
        reset = 1'b0;
        issue(4'b0001);
        observe(PING_BURST + 4, 0, 0, 4'b0000, o);
        checks++;
        if (o.first_low != 1 || o.low_cnt != PING_BURST || o.done_at != PING_BURST + 1 || o.to_cnt != 0) begin
            failures++;
            $display("FAIL reset_mid_recover: got first=%0d len=%0d done_at=%0d timeout=%0d expected 1/%0d/%0d/0",
                     o.first_low, o.low_cnt, o.done_at, o.to_cnt, PING_BURST, PING_BURST + 1);
        end
    endtask

    task automatic test_back_to_back;
        obs_t o;
        issue(4'b0001);
        observe(PING_BURST, 0, 0, 4'b0000, o);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_done_cycle: got done=%b busy=%b expected 1/0", done, busy);
        end
        issue(4'b0001);
        observe(PING_BURST + 4, 0, 0, 4'b0000, o);
        checks++;
        if (o.first_low != 1 || o.low_cnt != PING_BURST || o.done_at != PING_BURST + 1) begin
            failures++;
            $display("FAIL b2b_second: got first=%0d len=%0d done_at=%0d expected 1/%0d/%0d",
                     o.first_low, o.low_cnt, o.done_at, PING_BURST, PING_BURST + 1);
        end
    endtask

    initial begin
        reset           = 1'b1;
        stop            = 1'b0;
        handshake_ok    = 1'b0;
        send_poll       = 1'b0;
        send_ping       = 1'b0;
        send_u_exit     = 1'b0;
        send_warm_reset = 1'b0;
        test_reset();
        test_poll();
        test_ping();
        test_uexit();
        test_warm();
        test_priority();
        test_stop();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/usb3_lfps_tx.md
USB3_LFPS_TX -- requirements
Module: usb3_lfps_tx

Interface
REQ-001 Parameter POLL_BURST, default 125, Polling.LFPS burst length in local_clk cycles (1.0 us at 125 MHz).
REQ-002 Parameter POLL_REPEAT, default 1250, Polling.LFPS burst-start-to-burst-start period in cycles (10 us).
REQ-003 Parameter PING_BURST, default 16, Ping LFPS burst length in cycles (128 ns).
REQ-004 Parameter UEXIT_MIN, default 75, minimum U1/U2/U3-exit burst length in cycles (600 ns).
REQ-005 Parameter UEXIT_MAX, default 250000, U-exit handshake timeout in cycles (2 ms).
REQ-006 Parameter WARM_BURST, default 12500000, Warm Reset burst length in cycles (100 ms).
REQ-007 local_clk  in  1  single clock for all logic; one clock, no other clock domains.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 send_poll  in  1  request repeating Polling.LFPS.
REQ-010 send_ping  in  1  request one Ping burst.
REQ-011 send_u_exit  in  1  request U-exit LFPS with handshake.
REQ-012 send_warm_reset  in  1  request Warm Reset LFPS.
REQ-013 stop  in  1  abort any activity.
REQ-014 handshake_ok  in  1  partner LFPS detected (from LFPS receiver), already in local_clk domain.
REQ-015 tx_elecidle  out  1  PIPE TxElecIdle; 0 during a burst, 1 otherwise.
REQ-016 tx_oneszeros  out  1  PIPE TxOnesZeros; equals NOT tx_elecidle.
REQ-017 busy  out  1  high in any state other than IDLE.
REQ-018 done  out  1  one-cycle pulse on normal completion.
REQ-019 timeout  out  1  one-cycle pulse on U-exit handshake timeout.
REQ-020 poll_bursts  out  8  count of Polling bursts started since last send_poll, saturating at 255.

Function
REQ-021 States SHALL be IDLE, POLL_ON, POLL_OFF, PING, UEXIT, WARM; one down-counter, 24 bits, serves all timing.
REQ-022 Requests SHALL be sampled only in IDLE; requests while busy SHALL be ignored, not queued.
REQ-023 Simultaneous requests SHALL resolve with priority warm_reset > u_exit > poll > ping.
REQ-024 A request sampled at edge N SHALL give tx_elecidle=0 and busy=1 from edge N+1 (registered outputs, latency 1).
REQ-025 POLL_ON SHALL last POLL_BURST cycles, then POLL_OFF for POLL_REPEAT-POLL_BURST cycles, then POLL_ON again, indefinitely until stop.
REQ-026 poll_bursts SHALL clear to 0 on accepting send_poll and increment on each POLL_ON entry, holding at 255.
REQ-027 PING SHALL last PING_BURST cycles, then IDLE with done pulsed on the same edge as the return to IDLE.
REQ-028 UEXIT SHALL latch handshake_ok (sticky) at any cycle in the state; the burst ends at the first cycle at or after UEXIT_MIN with the latch set -> IDLE, done pulse.
REQ-029 handshake_ok before UEXIT_MIN SHALL NOT shorten the burst below UEXIT_MIN cycles.
REQ-030 UEXIT reaching UEXIT_MAX cycles without the latch set SHALL go to IDLE with timeout pulse and no done.
REQ-031 WARM SHALL last WARM_BURST cycles, then IDLE with done pulse.
REQ-032 stop SHALL force IDLE on the next edge from any state with tx_elecidle=1, no done or timeout pulse; stop wins over a same-cycle request.
REQ-033 done and timeout SHALL never assert in the same cycle.

Reset
REQ-034 While reset is high: state IDLE, tx_elecidle=1, tx_oneszeros=0, busy=0, done=0, timeout=0, poll_bursts=0, counter=0, handshake latch=0.
REQ-035 Reset asserted mid-burst SHALL end the burst asynchronously; first request is accepted on the first edge after reset deasserts.

Configuration
REQ-036 Macro USB3_LFPS_TX_WARM_RESET_EN defined: WARM state and send_warm_reset behave per REQ-031.
REQ-037 Macro undefined: WARM state absent, send_warm_reset ignored (port still present), counter width reduced to 18 bits, WARM_BURST unused.

Verification
REQ-038 send_poll pulse, run 35 us -> tx_elecidle low 125 cycles out of each 1250, four bursts started, poll_bursts=4, done never pulses.
REQ-039 send_ping pulse -> tx_elecidle low exactly 16 cycles starting 1 cycle later, done pulses once, busy low after.
REQ-040 send_u_exit, handshake_ok at cycle 10 -> burst 75 cycles, done; repeat with handshake_ok at cycle 500 -> burst ends at cycle 500 or 501, done; no handshake -> timeout at 250000 cycles.
REQ-041 send_warm_reset and send_ping same cycle (macro defined, WARM_BURST overridden to 1000) -> 1000-cycle burst, ping dropped; macro undefined -> ping accepted, 16-cycle burst.
REQ-042 stop at cycle 50 of POLL_ON, and reset at cycle 30 of UEXIT -> tx_elecidle=1 next edge (stop) or immediately (reset), busy=0, no done/timeout.
